// File: rtl/fifo_pkg.sv
// Shared sizing helpers for the parametrised FIFO: pointer width and depth legality.
package fifo_pkg;

    // Pointers carry one extra wrap bit beyond the storage index.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// DATA_W x DEPTH register array: one synchronous write port, one asynchronous read port, no reset.
module fifo_mem #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_param.sv
// Parametrised show-ahead synchronous FIFO with programmable half thresholds,
// sticky overflow/underflow flags and an occupancy high-watermark.
module fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              hresetn,
    input  logic              fifo_reset,
    input  logic              fifo_write,
    input  logic              fifo_read,
    input  logic [DATA_W-1:0] fifo_datain,
    input  logic [AW:0]       hfull_level,
    input  logic [AW:0]       hempty_level,
    input  logic              err_clr,
    output logic [DATA_W-1:0] fifo_dataout,
    output logic [AW:0]       fifo_count,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic              fifo_hfull,
    output logic              fifo_hempty,
    output logic              fifo_overflow,
    output logic              fifo_underflow,
    output logic [AW:0]       fifo_maxcount
);

    localparam int          PW       = ptr_w(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0] PTR_ONE  = (AW + 1)'(1);

    if (!is_pow2(DEPTH)) begin : g_bad_depth
        $fatal(1, "fifo_param: DEPTH must be a power of two and at least 2");
    end
    if (PW != AW + 1) begin : g_bad_aw
        $fatal(1, "fifo_param: AW must equal clog2(DEPTH)");
    end

    logic [AW:0]       wptr_q, wptr_d;
    logic [AW:0]       rptr_q, rptr_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic [AW:0]       maxcount_q, maxcount_d;

    logic [AW:0]       count;
    logic [AW:0]       count_next;
    logic              full;
    logic              empty;
    logic              rd_ok;
    logic              wr_ok;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wptr_q[AW-1:0]),
        .wdata (fifo_datain),
        .raddr (rptr_q[AW-1:0]),
        .rdata (mem_rdata)
    );

    // Occupancy is the modulo-2*DEPTH pointer difference; the wrap bit disambiguates full from empty.
    always_comb begin
        count = wptr_q - rptr_q;
        full  = (count == FULL_CNT);
        empty = (count == '0);
        rd_ok = fifo_read && !empty;
        wr_ok = fifo_write && (!full || rd_ok);
    end

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        maxcount_d  = maxcount_q;
        mem_we      = 1'b0;
        count_next  = count;

        if (fifo_reset) begin
            wptr_d      = '0;
            rptr_d      = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
            maxcount_d  = '0;
        end else begin
            if (wr_ok) begin
                wptr_d = wptr_q + PTR_ONE;
                mem_we = 1'b1;
            end
            if (rd_ok) begin
                rptr_d = rptr_q + PTR_ONE;
            end
            // A same-cycle set beats err_clr so no error event is ever lost.
            overflow_d  = (overflow_q && !err_clr) || (fifo_write && !wr_ok);
            underflow_d = (underflow_q && !err_clr) || (fifo_read && empty);

            count_next = wptr_d - rptr_d;
            if (count_next > maxcount_q) begin
                maxcount_d = count_next;
            end
        end
    end

    always_ff @(posedge clk or negedge hresetn) begin
        if (!hresetn) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            maxcount_q  <= '0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            maxcount_q  <= maxcount_d;
        end
    end

    // Storage is never reset, so the output is forced to zero whenever nothing is held.
    always_comb begin
        fifo_dataout   = empty ? '0 : mem_rdata;
        fifo_count     = count;
        fifo_full      = full;
        fifo_empty     = empty;
        fifo_hfull     = (count >= hfull_level);
        fifo_hempty    = (count <= hempty_level);
        fifo_overflow  = overflow_q;
        fifo_underflow = underflow_q;
        fifo_maxcount  = maxcount_q;
    end

endmodule

// File: tb/tb_fifo_param.sv
// Self-checking bench for fifo_param: constant vector table plus a queue-based scoreboard.
module tb_fifo_param;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;
    localparam int AW     = 3;

    logic              clk = 1'b0;
    logic              hresetn;
    logic              fifo_reset;
    logic              fifo_write;
    logic              fifo_read;
    logic [DATA_W-1:0] fifo_datain;
    logic [AW:0]       hfull_level;
    logic [AW:0]       hempty_level;
    logic              err_clr;
    logic [DATA_W-1:0] fifo_dataout;
    logic [AW:0]       fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_hfull;
    logic              fifo_hempty;
    logic              fifo_overflow;
    logic              fifo_underflow;
    logic [AW:0]       fifo_maxcount;

    always #5 clk = ~clk;

    fifo_param #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk            (clk),
        .hresetn        (hresetn),
        .fifo_reset     (fifo_reset),
        .fifo_write     (fifo_write),
        .fifo_read      (fifo_read),
        .fifo_datain    (fifo_datain),
        .hfull_level    (hfull_level),
        .hempty_level   (hempty_level),
        .err_clr        (err_clr),
        .fifo_dataout   (fifo_dataout),
        .fifo_count     (fifo_count),
        .fifo_full      (fifo_full),
        .fifo_empty     (fifo_empty),
        .fifo_hfull     (fifo_hfull),
        .fifo_hempty    (fifo_hempty),
        .fifo_overflow  (fifo_overflow),
        .fifo_underflow (fifo_underflow),
        .fifo_maxcount  (fifo_maxcount)
    );

    typedef struct {
        bit          wr;
        bit          rd;
        bit          clr;
        logic [31:0] din;
        int          cnt;
        logic [31:0] dout;
        bit          ovf;
        int          mx;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] sb[$];
    bit          m_ovf;
    bit          m_und;
    int          m_max;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void addv(input bit wr, input bit rd, input bit clr, input logic [31:0] din,
                                 input int cnt, input logic [31:0] dout, input bit ovf, input int mx);
        vec_t v;
        v.wr = wr; v.rd = rd; v.clr = clr; v.din = din;
        v.cnt = cnt; v.dout = dout; v.ovf = ovf; v.mx = mx;
        tbl.push_back(v);
    endfunction

    task automatic model_reset();
        sb.delete();
        m_ovf = 1'b0;
        m_und = 1'b0;
        m_max = 0;
    endtask

    task automatic check_model(input string tag);
        int c;
        c = sb.size();
        chk({tag, ".count"},  32'(fifo_count), 32'(c));
        chk({tag, ".full"},   32'(fifo_full), 32'(c == DEPTH));
        chk({tag, ".empty"},  32'(fifo_empty), 32'(c == 0));
        chk({tag, ".hfull"},  32'(fifo_hfull), 32'(c >= int'(hfull_level)));
        chk({tag, ".hempty"}, 32'(fifo_hempty), 32'(c <= int'(hempty_level)));
        chk({tag, ".ovf"},    32'(fifo_overflow), 32'(m_ovf));
        chk({tag, ".und"},    32'(fifo_underflow), 32'(m_und));
        chk({tag, ".max"},    32'(fifo_maxcount), 32'(m_max));
        chk({tag, ".dout"},   fifo_dataout, (c > 0) ? sb[0] : 32'h0);
    endtask

    // One clock of stimulus; the scoreboard decides acceptance from its own queue.
    task automatic step(input bit wr, input bit rd, input logic [31:0] din, input bit clr, input bit frst,
                        input string tag);
        int sz;
        bit rd_ok;
        bit wr_ok;
        fifo_write  = wr;
        fifo_read   = rd;
        fifo_datain = din;
        err_clr     = clr;
        fifo_reset  = frst;
        sz    = sb.size();
        rd_ok = rd && (sz > 0);
        wr_ok = wr && ((sz < DEPTH) || rd_ok);
        if (frst) begin
            model_reset();
        end else begin
            if (rd_ok) begin
                chk({tag, ".pop"}, fifo_dataout, sb[0]);
                void'(sb.pop_front());
            end
            if (wr_ok) sb.push_back(din);
            m_ovf = (m_ovf && !clr) || (wr && !wr_ok);
            m_und = (m_und && !clr) || (rd && (sz == 0));
            if (sb.size() > m_max) m_max = sb.size();
        end
        @(posedge clk);
        #1;
        fifo_write = 1'b0;
        fifo_read  = 1'b0;
        err_clr    = 1'b0;
        fifo_reset = 1'b0;
        check_model(tag);
    endtask

    initial begin
        hresetn      = 1'b0;
        fifo_reset   = 1'b0;
        fifo_write   = 1'b0;
        fifo_read    = 1'b0;
        fifo_datain  = '0;
        err_clr      = 1'b0;
        hfull_level  = '0;
        hempty_level = '0;
        model_reset();

        // Reset state: hfull follows hfull_level==0, hempty is 1 for any level.
        #12;
        check_model("rst_lvl0");
        hfull_level  = 4'd7;
        hempty_level = 4'd1;
        #1;
        chk("rst_hfull_l7", 32'(fifo_hfull), 32'h0);
        chk("rst_hempty_l1", 32'(fifo_hempty), 32'h1);
        @(negedge clk);
        hresetn = 1'b1;
        @(posedge clk);
        #1;

        // Fill, overflow, error clear and drain with constant expectations.
        for (int k = 1; k <= 8; k++) addv(1, 0, 0, 32'(k), k, 32'h1, 0, k);
        addv(1, 0, 0, 32'hDEAD, 8, 32'h1, 1, 8);
        addv(0, 1, 0, 32'h0, 7, 32'h2, 1, 8);
        addv(0, 0, 1, 32'h0, 7, 32'h2, 0, 8);
        for (int j = 2; j <= 8; j++) addv(0, 1, 0, 32'h0, 8 - j, (j < 8) ? 32'(j + 1) : 32'h0, 0, 8);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].wr, tbl[i].rd, tbl[i].din, tbl[i].clr, 1'b0, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d.cnt", i),    32'(fifo_count), 32'(tbl[i].cnt));
            chk($sformatf("tbl%0d.full", i),   32'(fifo_full), 32'(tbl[i].cnt == 8));
            chk($sformatf("tbl%0d.empty", i),  32'(fifo_empty), 32'(tbl[i].cnt == 0));
            chk($sformatf("tbl%0d.hfull", i),  32'(fifo_hfull), 32'(tbl[i].cnt >= 7));
            chk($sformatf("tbl%0d.hempty", i), 32'(fifo_hempty), 32'(tbl[i].cnt <= 1));
            chk($sformatf("tbl%0d.ovf", i),    32'(fifo_overflow), 32'(tbl[i].ovf));
            chk($sformatf("tbl%0d.max", i),    32'(fifo_maxcount), 32'(tbl[i].mx));
            chk($sformatf("tbl%0d.dout", i),   fifo_dataout, tbl[i].dout);
        end

        // Underflow with a simultaneous write: only the write lands.
        step(1, 1, 32'hA5, 0, 0, "und_wr");
        chk("und_wr.count", 32'(fifo_count), 32'h1);
        chk("und_wr.flag", 32'(fifo_underflow), 32'h1);
        chk("und_wr.dout", fifo_dataout, 32'hA5);
        step(0, 1, 32'h0, 1, 0, "und_clr");
        chk("und_clr.flag", 32'(fifo_underflow), 32'h0);

        // Full with simultaneous read and write.
        for (int k = 0; k < 8; k++) step(1, 0, 32'(16 + k), 0, 0, "full_fill");
        step(1, 1, 32'h18, 0, 0, "full_rw");
        chk("full_rw.count", 32'(fifo_count), 32'h8);
        chk("full_rw.ovf", 32'(fifo_overflow), 32'h0);
        for (int k = 0; k < 8; k++) begin
            chk("full_rw.order", fifo_dataout, 32'(17 + k));
            step(0, 1, 32'h0, 0, 0, "full_drain");
        end

        // Pointer wrap-around with single-entry occupancy.
        step(0, 0, 32'h0, 0, 1, "wrap_clr");
        for (int k = 0; k < 20; k++) begin
            step(1, 0, 32'(k), 0, 0, "wrap_push");
            chk("wrap.dout", fifo_dataout, 32'(k));
            step(0, 1, 32'h0, 0, 0, "wrap_pop");
        end
        chk("wrap.max", 32'(fifo_maxcount), 32'h1);

        // Synchronous clear with a write pending, and same-cycle threshold response.
        for (int k = 0; k < 5; k++) step(1, 0, 32'(32'h40 + k), 0, 0, "sr_fill");
        hfull_level = 4'd5;
        #1;
        chk("thr_hfull_eq", 32'(fifo_hfull), 32'h1);
        hfull_level = 4'd6;
        hempty_level = 4'd5;
        #1;
        chk("thr_hfull_above", 32'(fifo_hfull), 32'h0);
        chk("thr_hempty_eq", 32'(fifo_hempty), 32'h1);
        hfull_level  = 4'd7;
        hempty_level = 4'd1;
        step(1, 0, 32'h55, 0, 1, "sreset");
        chk("sreset.count", 32'(fifo_count), 32'h0);
        chk("sreset.empty", 32'(fifo_empty), 32'h1);
        chk("sreset.max", 32'(fifo_maxcount), 32'h0);

        // Asynchronous reset in the middle of a write burst.
        for (int k = 0; k < 4; k++) step(1, 0, 32'(32'h70 + k), 0, 0, "ar_fill");
        step(1, 0, 32'hBAD, 0, 0, "ar_fill");
        fifo_write  = 1'b1;
        fifo_datain = 32'h77;
        #2;
        hresetn = 1'b0;
        #1;
        model_reset();
        check_model("areset");
        @(negedge clk);
        fifo_write = 1'b0;
        hresetn    = 1'b1;
        @(posedge clk);
        #1;
        check_model("areset_rel");

        // Random traffic against the scoreboard.
        for (int k = 0; k < 300; k++) begin
            if ((k % 37) == 0) begin
                hfull_level  = 4'($urandom_range(0, 8));
                hempty_level = 4'($urandom_range(0, 8));
            end
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 60) == 0), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
